// File: rtl/counters_pkg.sv
// Shared counter definitions: FSM state encoding and default count width.
package counters_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cnt_state_e;

endpackage

// File: rtl/down_counter_load_if.sv
// Control/status bundle for the loadable down counter.
interface down_counter_load_if
    import counters_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             bo;
    logic             busy;

    modport master (
        output en, load, load_val, start, auto_reload,
        input  q, bo, busy
    );

    modport slave (
        input  en, load, load_val, start, auto_reload,
        output q, bo, busy
    );
endinterface

// File: rtl/down_counter_load.sv
// Loadable down counter with one-shot / periodic reload and a registered borrow pulse.
module down_counter_load
    import counters_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    down_counter_load_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    cnt_state_e       state_r;
    cnt_state_e       state_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] rld_r;
    logic [WIDTH-1:0] rld_s;
    logic             bo_r;
    logic             bo_s;

    // Next-state and datapath: load beats start beats en; q==0 always takes the terminal branch.
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        rld_s   = rld_r;
        bo_s    = 1'b0;
        if (bus.load) begin
            rld_s = bus.load_val;
            q_s   = bus.load_val;
            if (bus.start) begin
                state_s = RUN;
            end else begin
                state_s = state_r;
            end
        end else if (bus.start) begin
            q_s     = rld_r;
            state_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (bus.en) begin
                        if (q_r != ZERO) begin
                            q_s = q_r - ONE;
                        end else begin
                            bo_s = 1'b1;
                            if (bus.auto_reload) begin
                                q_s = rld_r;
                            end else begin
                                q_s     = q_r;
                                state_s = IDLE;
                            end
                        end
                    end else begin
                        q_s = q_r;
                    end
                end
                IDLE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, count, reload and borrow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            q_r     <= ZERO;
            rld_r   <= ZERO;
            bo_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            rld_r   <= rld_s;
            bo_r    <= bo_s;
        end
    end

    assign bus.q    = q_r;
    assign bus.bo   = bo_r;
    assign bus.busy = (state_r == RUN);

endmodule

// File: tb/tb_down_counter_load.sv
// Directed self-checking bench for down_counter_load (WIDTH=8 and WIDTH=4 instances).
module tb_down_counter_load;

    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    down_counter_load_if #(.WIDTH(8)) bus8 ();
    down_counter_load_if #(.WIDTH(4)) bus4 ();

    down_counter_load #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    down_counter_load #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared = n_compared + 1;
        if (obs !== exp) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input int q, input int bo, input int busy);
        check_eq({tag, ".q"},    32'(bus8.q),    32'(q));
        check_eq({tag, ".bo"},   32'(bus8.bo),   32'(bo));
        check_eq({tag, ".busy"}, 32'(bus8.busy), 32'(busy));
    endtask

    initial begin
        int qm;
        int bom;
        int busym;
        int bo_cnt;
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1;
        bus8.en = 1'b0; bus8.load = 1'b0; bus8.load_val = 8'd0; bus8.start = 1'b0; bus8.auto_reload = 1'b0;
        bus4.en = 1'b0; bus4.load = 1'b0; bus4.load_val = 4'd0; bus4.start = 1'b0; bus4.auto_reload = 1'b0;
        step();
        step();
        chk8("reset", 0, 0, 0);

        // Reset overrides a simultaneous load and start.
        bus8.load = 1'b1; bus8.load_val = 8'd9; bus8.start = 1'b1;
        step();
        chk8("rst_over_load", 0, 0, 0);
        rst = 1'b0; bus8.load = 1'b0; bus8.start = 1'b0;
        step();
        chk8("idle_after_rst", 0, 0, 0);

        // One-shot from 5.
        bus8.load = 1'b1; bus8.load_val = 8'd5;
        step();
        chk8("os_load", 5, 0, 0);
        bus8.load = 1'b0; bus8.start = 1'b1; bus8.en = 1'b1;
        step();
        chk8("os_start", 5, 0, 1);
        bus8.start = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            step();
            chk8("os_dec", i, 0, 1);
        end
        step();
        chk8("os_term", 0, 1, 0);
        step();
        chk8("os_idle", 0, 0, 0);

        // Periodic R=3 for 12 en ticks.
        bus8.en = 1'b0; bus8.load = 1'b1; bus8.load_val = 8'd3;
        step();
        bus8.load = 1'b0; bus8.start = 1'b1;
        step();
        chk8("per_start", 3, 0, 1);
        bus8.start = 1'b0; bus8.auto_reload = 1'b1; bus8.en = 1'b1;
        qm = 3; bo_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (qm == 0) begin qm = 3; bom = 1; end else begin qm = qm - 1; bom = 0; end
            step();
            chk8("per", qm, bom, 1);
            bo_cnt = bo_cnt + 32'(bus8.bo);
        end
        check_eq("per_bo_count", 32'(bo_cnt), 32'd3);

        // R=0 periodic: borrow every cycle, q pinned at 0.
        bus8.en = 1'b0; bus8.load = 1'b1; bus8.load_val = 8'd0; bus8.start = 1'b1;
        step();
        chk8("r0_start", 0, 0, 1);
        bus8.load = 1'b0; bus8.start = 1'b0; bus8.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk8("r0_bo", 0, 1, 1);
        end

        // Gated en, one-shot R=2, en every 3rd cycle.
        bus8.en = 1'b0; bus8.auto_reload = 1'b0; bus8.load = 1'b1; bus8.load_val = 8'd2;
        step();
        bus8.load = 1'b0; bus8.start = 1'b1;
        step();
        chk8("gate_start", 2, 0, 1);
        bus8.start = 1'b0;
        qm = 2; busym = 1;
        for (int c = 0; c < 12; c++) begin
            bus8.en = ((c % 3) == 2);
            bom = 0;
            if (bus8.en && busym == 1) begin
                if (qm == 0) begin bom = 1; busym = 0; end else begin qm = qm - 1; end
            end
            step();
            chk8("gate", qm, bom, busym);
        end

        // Load+start collision while running at q=1 with en.
        bus8.en = 1'b0; bus8.load = 1'b1; bus8.load_val = 8'd3; bus8.start = 1'b1;
        step();
        bus8.load = 1'b0; bus8.start = 1'b0; bus8.en = 1'b1;
        step();
        step();
        chk8("col_pre", 1, 0, 1);
        bus8.load = 1'b1; bus8.load_val = 8'd7; bus8.start = 1'b1;
        step();
        chk8("col", 7, 0, 1);
        bus8.load = 1'b0; bus8.start = 1'b0;
        step();
        chk8("col_next", 6, 0, 1);

        // Reset mid-run at q=4, then start with rld cleared.
        bus8.en = 1'b0; bus8.load = 1'b1; bus8.load_val = 8'd10; bus8.start = 1'b1;
        step();
        bus8.load = 1'b0; bus8.start = 1'b0; bus8.en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk8("mid_pre", 4, 0, 1);
        rst = 1'b1;
        step();
        chk8("mid_rst", 0, 0, 0);
        rst = 1'b0; bus8.en = 1'b0; bus8.start = 1'b1;
        step();
        chk8("mid_start", 0, 0, 1);
        bus8.start = 1'b0; bus8.en = 1'b1;
        step();
        chk8("mid_bo", 0, 1, 0);
        step();
        chk8("mid_after", 0, 0, 0);
        bus8.en = 1'b0;

        // WIDTH=4 boundary: R=15 periodic, 16-tick period with clean wrap.
        bus4.load = 1'b1; bus4.load_val = 4'd15; bus4.start = 1'b1; bus4.auto_reload = 1'b1;
        step();
        check_eq("w4_start.q", 32'(bus4.q), 32'd15);
        check_eq("w4_start.busy", 32'(bus4.busy), 32'd1);
        bus4.load = 1'b0; bus4.start = 1'b0; bus4.en = 1'b1;
        qm = 15; bo_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (qm == 0) begin qm = 15; bom = 1; end else begin qm = qm - 1; bom = 0; end
            step();
            check_eq("w4.q", 32'(bus4.q), 32'(qm));
            check_eq("w4.bo", 32'(bus4.bo), 32'(bom));
            bo_cnt = bo_cnt + 32'(bus4.bo);
        end
        check_eq("w4_bo_count", 32'(bo_cnt), 32'd2);
        bus4.en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
